// File: rtl/gol_pkg.sv
// Shared types for the cell-state RAM arbiter: swap FSM states, requester
// identifiers and the read-tag record that travels alongside a RAM read.
package gol_pkg;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    SWAP
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_VGA,
    SRC_ENG,
    SRC_CPU
  } src_t;

  typedef struct packed {
    logic valid;
    src_t src;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, src: SRC_VGA};

  function automatic logic tag_hit(input tag_t t, input src_t s);
    return t.valid && (t.src == s);
  endfunction

endpackage

// File: rtl/cell_ram_arbiter_if.sv
// Bundle of requester, status and RAM-side signals around the cell RAM arbiter.
// slave = arbiter side, master = the surrounding system (requesters + RAM).
interface cell_ram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_gen_done;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W:0]   cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_vblank;
  logic              disp_bank;
  logic              swap_done;

  logic [ADDR_W:0]   ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  eng_req, eng_we, eng_addr, eng_wdata, eng_gen_done,
    output eng_gnt, eng_rvalid, eng_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_vblank,
    output disp_bank, swap_done,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output eng_req, eng_we, eng_addr, eng_wdata, eng_gen_done,
    input  eng_gnt, eng_rvalid, eng_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_vblank,
    input  disp_bank, swap_done,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/cell_arb_rr2.sv
// Two-way round-robin picker: pointer 0 prefers side a, and it toggles after
// every grant it issues. enable=0 blocks both grants and freezes the pointer.
module cell_arb_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic enable,
  output logic gnt_a,
  output logic gnt_b
);

  logic rr_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (enable) begin
      if (req_a && (!req_b || !rr_q)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      rr_q <= ~rr_q;
    end
  end

endmodule

// File: rtl/cell_ram_arbiter.sv
// Single-port cell RAM arbiter with VGA priority, engine/CPU round-robin and
// vblank bank swap. Define CELL_ARB_CPU_EN to enable the CPU port.
module cell_ram_arbiter
  import gol_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                Clk,
  input  logic                Reset_h,
  cell_ram_arbiter_if.slave   bus
);

  localparam int RAM_AW = ADDR_W + 1;

  arb_state_t        state_q;
  logic              disp_bank_q;
  logic              swap_done_q;

  logic [RAM_AW-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;

  logic vga_win;
  logic eng_win;
  logic cpu_win;
  logic eng_req_eff;
  logic any_gnt;
  logic pipe_empty;

  // Engine is frozen while a finished generation waits for its bank swap.
  assign eng_req_eff = bus.eng_req && (state_q != PEND);
  assign vga_win     = bus.vga_req;

`ifdef CELL_ARB_CPU_EN
  cell_arb_rr2 u_rr (
    .clk    (Clk),
    .rst    (Reset_h),
    .req_a  (eng_req_eff),
    .req_b  (bus.cpu_req),
    .enable (!bus.vga_req),
    .gnt_a  (eng_win),
    .gnt_b  (cpu_win)
  );
`else
  logic unused_cpu;
  assign unused_cpu = ^{bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign eng_win    = eng_req_eff && !bus.vga_req;
  assign cpu_win    = 1'b0;
`endif

  assign any_gnt    = vga_win || eng_win || cpu_win;
  assign pipe_empty = !tag1_q.valid && !tag2_q.valid;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = TAG_EMPTY;
    if (vga_win) begin
      ram_addr_d = {disp_bank_q, bus.vga_addr};
      tag1_d     = '{valid: 1'b1, src: SRC_VGA};
    end else if (eng_win) begin
      // Engine reads the displayed generation and writes the hidden one.
      ram_addr_d  = {(bus.eng_we ? ~disp_bank_q : disp_bank_q), bus.eng_addr};
      ram_we_d    = bus.eng_we;
      ram_wdata_d = bus.eng_wdata;
      tag1_d      = '{valid: !bus.eng_we, src: SRC_ENG};
    end
`ifdef CELL_ARB_CPU_EN
    else if (cpu_win) begin
      ram_addr_d  = bus.cpu_addr;
      ram_we_d    = bus.cpu_we;
      ram_wdata_d = bus.cpu_wdata;
      tag1_d      = '{valid: !bus.cpu_we, src: SRC_CPU};
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag1_q      <= TAG_EMPTY;
      tag2_q      <= TAG_EMPTY;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
    end
  end

  // Swap only when nothing is in flight or being granted, so no access
  // straddles the bank change.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state_q     <= RUN;
      disp_bank_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.eng_gen_done) begin
            state_q <= PEND;
          end
        end
        PEND: begin
          if (bus.vga_vblank && pipe_empty && !any_gnt) begin
            state_q     <= SWAP;
            disp_bank_q <= ~disp_bank_q;
            swap_done_q <= 1'b1;
          end
        end
        SWAP: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.vga_gnt    = vga_win;
  assign bus.vga_rvalid = tag_hit(tag2_q, SRC_VGA);
  assign bus.vga_rdata  = bus.ram_rdata;

  assign bus.eng_gnt    = eng_win;
  assign bus.eng_rvalid = tag_hit(tag2_q, SRC_ENG);
  assign bus.eng_rdata  = bus.ram_rdata;

`ifdef CELL_ARB_CPU_EN
  assign bus.cpu_gnt    = cpu_win;
  assign bus.cpu_rvalid = tag_hit(tag2_q, SRC_CPU);
  assign bus.cpu_rdata  = bus.ram_rdata;
`else
  assign bus.cpu_gnt    = 1'b0;
  assign bus.cpu_rvalid = 1'b0;
  assign bus.cpu_rdata  = '0;
`endif

  assign bus.disp_bank  = disp_bank_q;
  assign bus.swap_done  = swap_done_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_cell_ram_arbiter.sv
// Scoreboard bench for cell_ram_arbiter: a synchronous RAM model, directed
// stimulus pushing expected reads, and a monitor that pops on every rvalid.
module tb_cell_ram_arbiter;

  logic Clk;
  logic Reset_h;
  logic preload;

  cell_ram_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  cell_ram_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
    .Clk     (Clk),
    .Reset_h (Reset_h),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous single-port RAM with a small hand-chosen initial image.
  logic [7:0] mem [0:32767];
  always @(posedge Clk) begin
    if (preload) begin
      mem[15'h0010] <= 8'hA5;
      mem[15'h0020] <= 8'h5A;
      mem[15'h0100] <= 8'h11;
      mem[15'h4010] <= 8'h77;
      mem[15'h4100] <= 8'h00;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    int         src;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
`ifdef CELL_ARB_CPU_EN
  logic exp_rr = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input int src, input logic [7:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
  endtask

  // Called at a negedge after inputs are set: checks grants, records reads.
  task automatic step(input logic ev, input logic ee, input logic ec,
                      input logic [7:0] dv, input logic [7:0] de, input logic [7:0] dc);
    #1;
    check("vga_gnt", bus.vga_gnt, ev);
    check("eng_gnt", bus.eng_gnt, ee);
    check("cpu_gnt", bus.cpu_gnt, ec);
    if (ev) push(0, dv);
    if (ee && !bus.eng_we) push(1, de);
    if (ec && !bus.cpu_we) push(2, dc);
`ifdef CELL_ARB_CPU_EN
    if (ee || ec) exp_rr = ~exp_rr;
`endif
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ram_we"},     bus.ram_we, 0);
    check({tag, "_ram_addr"},   bus.ram_addr, 0);
    check({tag, "_ram_wdata"},  bus.ram_wdata, 0);
    check({tag, "_disp_bank"},  bus.disp_bank, 0);
    check({tag, "_swap_done"},  bus.swap_done, 0);
    check({tag, "_rvalids"},    {bus.vga_rvalid, bus.eng_rvalid, bus.cpu_rvalid}, 0);
    check({tag, "_gnts"},       {bus.vga_gnt, bus.eng_gnt, bus.cpu_gnt}, 0);
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  int         mon_n;
  int         mon_src;
  logic [7:0] mon_data;
  exp_t       mon_e;
  always @(negedge Clk) begin
    if (Reset_h === 1'b0) begin
      mon_n = int'(bus.vga_rvalid) + int'(bus.eng_rvalid) + int'(bus.cpu_rvalid);
      if (mon_n > 1) begin
        tests++;
        fails++;
        $display("FAIL multi_rvalid got=%0d required=1 cycle=%0d", mon_n, cyc);
      end else if (mon_n == 1) begin
        mon_src  = bus.vga_rvalid ? 0 : (bus.eng_rvalid ? 1 : 2);
        mon_data = (mon_src == 0) ? bus.vga_rdata : ((mon_src == 1) ? bus.eng_rdata : bus.cpu_rdata);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rvalid got src=%0d data=%0h cycle=%0d required none", mon_src, mon_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.src != mon_src || mon_e.data != mon_data || mon_e.cyc != cyc) begin
            fails++;
            $display("FAIL rvalid got src=%0d data=%0h cycle=%0d required src=%0d data=%0h cycle=%0d",
                     mon_src, mon_data, cyc, mon_e.src, mon_e.data, mon_e.cyc);
          end else begin
            $display("[TB] read src=%0d data=%0h cycle=%0d ok", mon_src, mon_data, cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic xe, xc, found;

  initial begin
    Reset_h = 1'b1;
    preload = 1'b1;
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = '0; bus.eng_gen_done = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_vblank = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    reset_checks("reset");
    preload = 1'b0;
    Reset_h = 1'b0;
    @(negedge Clk);

    // Priority: VGA wins 4 cycles over both others, then eng/cpu alternate.
    bus.vga_req = 1; bus.vga_addr = 14'h0020;
    bus.eng_req = 1; bus.eng_addr = 14'h0010;
    bus.cpu_req = 1; bus.cpu_addr = 15'h4010;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h00);
    bus.vga_req = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef CELL_ARB_CPU_EN
      xe = !exp_rr; xc = exp_rr;
`else
      xe = 1'b1; xc = 1'b0;
`endif
      step(1'b0, xe, xc, 8'h00, 8'hA5, 8'h77);
      $display("[TB] prio cycle %0d eng=%0b cpu=%0b", i, xe, xc);
    end
    bus.eng_req = 0; bus.cpu_req = 0;
    idle(3);

    // Read latency: single engine read of bank-0 word 0x0010.
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 14'h0010;
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h00);
    bus.eng_req = 0;
    idle(3);

    // Engine write lands in the hidden bank; VGA still sees the old word.
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 14'h0100; bus.eng_wdata = 8'h3C;
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    bus.eng_req = 0; bus.eng_we = 0;
    check("eng_wr_ram_addr", bus.ram_addr, 15'h4100);
    check("eng_wr_ram_we", bus.ram_we, 1);
    check("eng_wr_ram_wdata", bus.ram_wdata, 8'h3C);
    $display("[TB] engine write addr=%0h", bus.ram_addr);
    bus.vga_req = 1; bus.vga_addr = 14'h0100;
    step(1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00);
    bus.vga_req = 0;
    idle(3);

    // Swap: pending outside vblank blocks the engine, then swaps in vblank.
    bus.eng_gen_done = 1;
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    bus.eng_gen_done = 0;
    bus.eng_req = 1; bus.eng_addr = 14'h0010;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      check("pend_swap_done", bus.swap_done, 0);
      check("pend_disp_bank", bus.disp_bank, 0);
    end
    bus.eng_req = 0;
    bus.vga_vblank = 1;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      if (bus.swap_done) found = 1'b1;
    end
    check("swap_done_seen", found, 1);
    check("swap_disp_bank", bus.disp_bank, 1);
    $display("[TB] swap disp_bank=%0b", bus.disp_bank);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("swap_pulse_width", bus.swap_done, 0);
    bus.vga_vblank = 0;
    bus.vga_req = 1; bus.vga_addr = 14'h0100;
    step(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00);
    bus.vga_req = 0;
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 14'h0200; bus.eng_wdata = 8'h99;
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    bus.eng_req = 0; bus.eng_we = 0;
    check("eng_wr_bank0_addr", bus.ram_addr, 15'h0200);
    check("eng_wr_bank0_we", bus.ram_we, 1);
    idle(3);

    // Reset arriving the cycle after a read grant discards that read.
`ifdef CELL_ARB_CPU_EN
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0020;
    #1;
    check("midrd_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge Clk);
    bus.cpu_req = 0;
`else
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 14'h0010;
    #1;
    check("midrd_eng_gnt", bus.eng_gnt, 1);
    @(negedge Clk);
    bus.eng_req = 0;
`endif
    Reset_h = 1'b1;
    #1;
    reset_checks("midrd");
`ifdef CELL_ARB_CPU_EN
    exp_rr = 1'b0;
`endif
    repeat (2) @(negedge Clk);
    Reset_h = 1'b0;
    idle(4);
    $display("[TB] mid-read reset done");

    // CPU held for 20 cycles alongside the engine, no VGA.
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 14'h0010;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0020;
    for (int i = 0; i < 20; i++) begin
`ifdef CELL_ARB_CPU_EN
      xe = !exp_rr; xc = exp_rr;
`else
      xe = 1'b1; xc = 1'b0;
`endif
      step(1'b0, xe, xc, 8'h00, 8'hA5, 8'h5A);
    end
    $display("[TB] held cpu_req 20 cycles");
    bus.eng_req = 0; bus.cpu_req = 0;
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
